// File: rtl/reg_file_mt_pkg.sv
// Shared definitions for the multi-context register file: FSM encoding and
// the {thread,reg} flat-address helper.
package reg_file_mt_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int unsigned flat_addr(input int unsigned thread,
                                            input int unsigned regidx,
                                            input int unsigned log2numregs);
    return (thread << log2numregs) | regidx;
  endfunction

endpackage

// File: rtl/reg_file_mt_if.sv
// Bus bundle for reg_file_mt: two read ports, one write port and the ready flag.
// master drives addresses/data, slave is the register file.
interface reg_file_mt_if #(
  parameter int WIDTH          = 32,
  parameter int LOG2NUMREGS    = 5,
  parameter int LOG2NUMTHREADS = 2
);
  logic [LOG2NUMTHREADS-1:0] a_thread;
  logic [LOG2NUMREGS-1:0]    a_reg;
  logic                      a_en;
  logic [WIDTH-1:0]          a_readdataout;
  logic [LOG2NUMTHREADS-1:0] b_thread;
  logic [LOG2NUMREGS-1:0]    b_reg;
  logic                      b_en;
  logic [WIDTH-1:0]          b_readdataout;
  logic [LOG2NUMTHREADS-1:0] c_thread;
  logic [LOG2NUMREGS-1:0]    c_reg;
  logic [WIDTH-1:0]          c_writedatain;
  logic                      c_we;
  logic                      ready;

  modport master (
    output a_thread, a_reg, a_en, b_thread, b_reg, b_en,
           c_thread, c_reg, c_writedatain, c_we,
    input  a_readdataout, b_readdataout, ready
  );

  modport slave (
    input  a_thread, a_reg, a_en, b_thread, b_reg, b_en,
           c_thread, c_reg, c_writedatain, c_we,
    output a_readdataout, b_readdataout, ready
  );
endinterface

// File: rtl/reg_file_mt_rdport.sv
// One synchronous read port: output register with enable hold and zero-reg masking.
// With REG_FILE_MT_BYPASS_EN defined it also forwards a same-address write.
module reg_file_mt_rdport
  import reg_file_mt_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int LOG2NUMREGS = 5,
  parameter int ADDRW       = 7,
  parameter int ZERO_REG    = 1
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic                   init_i,
  input  logic                   en_i,
  input  logic [LOG2NUMREGS-1:0] reg_i,
  input  logic [ADDRW-1:0]       addr_i,
  input  logic [WIDTH-1:0]       mem_data_i,
`ifdef REG_FILE_MT_BYPASS_EN
  input  logic                   wr_en_i,
  input  logic [ADDRW-1:0]       wr_addr_i,
  input  logic [WIDTH-1:0]       wr_data_i,
`endif
  output logic [WIDTH-1:0]       data_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_hit;

  assign zero_hit = (ZERO_REG != 0) && (reg_i == '0);

  // Reads during the clear sequence return 0 since storage is not yet valid.
  always_comb begin
    data_d = data_q;
    if (en_i) begin
      if (init_i || zero_hit) data_d = '0;
`ifdef REG_FILE_MT_BYPASS_EN
      else if (wr_en_i && (wr_addr_i == addr_i)) data_d = wr_data_i;
`endif
      else data_d = mem_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) data_q <= '0;
    else           data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/reg_file_mt.sv
// Multi-context register file: NUMTHREADS banks of NUMREGS x WIDTH, cleared by
// hardware after reset. Define REG_FILE_MT_BYPASS_EN for write-to-read forwarding.
module reg_file_mt
  import reg_file_mt_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int NUMREGS        = 32,
  parameter int LOG2NUMREGS    = 5,
  parameter int NUMTHREADS     = 4,
  parameter int LOG2NUMTHREADS = 2,
  parameter int ZERO_REG       = 1
) (
  input logic         clk,
  input logic         resetn,
  reg_file_mt_if.slave bus
);

  localparam int ADDRW = LOG2NUMTHREADS + LOG2NUMREGS;
  localparam int DEPTH = NUMTHREADS * NUMREGS;

  state_e           state_q, state_d;
  logic [ADDRW-1:0] cnt_q, cnt_d;
  logic             ready_q;
  logic             init;
  logic             wr_en;
  logic [ADDRW-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [ADDRW-1:0] a_addr, b_addr, c_addr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign a_addr = ADDRW'(flat_addr(32'(bus.a_thread), 32'(bus.a_reg), LOG2NUMREGS));
  assign b_addr = ADDRW'(flat_addr(32'(bus.b_thread), 32'(bus.b_reg), LOG2NUMREGS));
  assign c_addr = ADDRW'(flat_addr(32'(bus.c_thread), 32'(bus.c_reg), LOG2NUMREGS));
  assign init   = (state_q == ST_INIT);

  // INIT owns the write port to zero one entry per cycle; RUN hands it to port c.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = c_addr;
    wr_data = bus.c_writedatain;
    case (state_q)
      ST_INIT: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == ADDRW'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_en = bus.c_we && !((ZERO_REG != 0) && (bus.c_reg == '0));
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == ST_RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && wr_en) mem[wr_addr] <= wr_data;
  end

`ifdef REG_FILE_MT_BYPASS_EN
  logic run_we;
  assign run_we = (state_q == ST_RUN) && wr_en;
`endif

  reg_file_mt_rdport #(
    .WIDTH(WIDTH), .LOG2NUMREGS(LOG2NUMREGS), .ADDRW(ADDRW), .ZERO_REG(ZERO_REG)
  ) u_rd_a (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .init_i     (init),
    .en_i       (bus.a_en),
    .reg_i      (bus.a_reg),
    .addr_i     (a_addr),
    .mem_data_i (mem[a_addr]),
`ifdef REG_FILE_MT_BYPASS_EN
    .wr_en_i    (run_we),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
`endif
    .data_o     (bus.a_readdataout)
  );

  reg_file_mt_rdport #(
    .WIDTH(WIDTH), .LOG2NUMREGS(LOG2NUMREGS), .ADDRW(ADDRW), .ZERO_REG(ZERO_REG)
  ) u_rd_b (
    .clk_i      (clk),
    .resetn_i   (resetn),
    .init_i     (init),
    .en_i       (bus.b_en),
    .reg_i      (bus.b_reg),
    .addr_i     (b_addr),
    .mem_data_i (mem[b_addr]),
`ifdef REG_FILE_MT_BYPASS_EN
    .wr_en_i    (run_we),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
`endif
    .data_o     (bus.b_readdataout)
  );

  assign bus.ready = ready_q;

endmodule

// File: tb/tb_reg_file_mt.sv
// Bench for reg_file_mt: two DUTs (ZERO_REG=1 and ZERO_REG=0) share one stimulus
// stream and are compared every cycle against an array-based model.
module tb_reg_file_mt;

  localparam int NUMREGS = 32;
  localparam int DEPTH   = 128;

  typedef struct packed {
    logic        rstn;
    logic        aEn;
    logic [1:0]  aT;
    logic [4:0]  aR;
    logic        bEn;
    logic [1:0]  bT;
    logic [4:0]  bR;
    logic        cWe;
    logic [1:0]  cT;
    logic [4:0]  cR;
    logic [31:0] cD;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        aEn, bEn, cWe;
  logic [1:0]  aT, bT, cT;
  logic [4:0]  aR, bR, cR;
  logic [31:0] cD;

  int cmpCount  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  reg_file_mt_if busZ ();
  reg_file_mt_if busN ();

  assign busZ.a_thread = aT;  assign busN.a_thread = aT;
  assign busZ.a_reg    = aR;  assign busN.a_reg    = aR;
  assign busZ.a_en     = aEn; assign busN.a_en     = aEn;
  assign busZ.b_thread = bT;  assign busN.b_thread = bT;
  assign busZ.b_reg    = bR;  assign busN.b_reg    = bR;
  assign busZ.b_en     = bEn; assign busN.b_en     = bEn;
  assign busZ.c_thread = cT;  assign busN.c_thread = cT;
  assign busZ.c_reg    = cR;  assign busN.c_reg    = cR;
  assign busZ.c_writedatain = cD; assign busN.c_writedatain = cD;
  assign busZ.c_we     = cWe; assign busN.c_we     = cWe;

  reg_file_mt #(.ZERO_REG(1)) dutZ (.clk(clk), .resetn(rstn), .bus(busZ));
  reg_file_mt #(.ZERO_REG(0)) dutN (.clk(clk), .resetn(rstn), .bus(busN));

  // Reference model: plain arrays plus a countdown of remaining clear cycles.
  logic [31:0] memZ [DEPTH];
  logic [31:0] memN [DEPTH];
  logic [31:0] expAZ, expBZ, expAN, expBN;
  logic        expReady;
  int          clearLeft;
  bit          modelLive = 1'b0;

  function automatic logic [31:0] modelRead(input bit zero, input logic [1:0] t, input logic [4:0] r);
    int idx;
    idx = int'(t) * NUMREGS + int'(r);
    if (zero && r == 5'd0) return 32'd0;
`ifdef REG_FILE_MT_BYPASS_EN
    if (cWe && cT == t && cR == r) return cD;
`endif
    return zero ? memZ[idx] : memN[idx];
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      modelLive = 1'b1;
      expAZ = 0; expBZ = 0; expAN = 0; expBN = 0;
      expReady  = 1'b0;
      clearLeft = DEPTH;
      for (int i = 0; i < DEPTH; i++) begin
        memZ[i] = 32'd0;
        memN[i] = 32'd0;
      end
    end else if (modelLive) begin
      if (clearLeft > 0) begin
        if (aEn) begin expAZ = 0; expAN = 0; end
        if (bEn) begin expBZ = 0; expBN = 0; end
        clearLeft--;
        if (clearLeft == 0) expReady = 1'b1;
      end else begin
        if (aEn) begin expAZ = modelRead(1'b1, aT, aR); expAN = modelRead(1'b0, aT, aR); end
        if (bEn) begin expBZ = modelRead(1'b1, bT, bR); expBN = modelRead(1'b0, bT, bR); end
        if (cWe) begin
          if (cR != 5'd0) memZ[int'(cT) * NUMREGS + int'(cR)] = cD;
          memN[int'(cT) * NUMREGS + int'(cR)] = cD;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    cmpCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %08h, expected %08h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cyc_a_z",     busZ.a_readdataout, expAZ);
      checkOutput("cyc_b_z",     busZ.b_readdataout, expBZ);
      checkOutput("cyc_a_n",     busN.a_readdataout, expAN);
      checkOutput("cyc_b_n",     busN.b_readdataout, expBN);
      checkOutput("cyc_ready_z", 32'(busZ.ready), 32'(expReady));
      checkOutput("cyc_ready_n", 32'(busN.ready), 32'(expReady));
    end
  end

  function automatic vec_t nopVec();
    vec_t v;
    v = '0;
    v.rstn = 1'b1;
    return v;
  endfunction

  function automatic vec_t wrVec(input logic [1:0] t, input logic [4:0] r, input logic [31:0] d);
    vec_t v;
    v = nopVec();
    v.cWe = 1'b1; v.cT = t; v.cR = r; v.cD = d;
    return v;
  endfunction

  function automatic vec_t rdVec(input logic [1:0] at, input logic [4:0] ar,
                                 input logic [1:0] bt, input logic [4:0] br);
    vec_t v;
    v = nopVec();
    v.aEn = 1'b1; v.aT = at; v.aR = ar;
    v.bEn = 1'b1; v.bT = bt; v.bR = br;
    return v;
  endfunction

  // Drive one vector and advance to the next falling edge.
  task automatic applyStimulus(input vec_t v);
    rstn = v.rstn;
    aEn = v.aEn; aT = v.aT; aR = v.aR;
    bEn = v.bEn; bT = v.bT; bR = v.bR;
    cWe = v.cWe; cT = v.cT; cR = v.cR; cD = v.cD;
    @(negedge clk);
  endtask

  task automatic waitReady(input string name);
    int n;
    n = 0;
    do begin
      applyStimulus(nopVec());
      n++;
    end while (!busZ.ready && n < 400);
    checkOutput(name, 32'(n), 32'd128);
  endtask

  initial begin
    vec_t v;
    v = nopVec();
    v.rstn = 1'b0;
    rstn = 1'b0; aEn = 0; bEn = 0; cWe = 0;
    aT = 0; bT = 0; cT = 0; aR = 0; bR = 0; cR = 0; cD = 0;
    @(negedge clk);
    applyStimulus(v);
    applyStimulus(v);
    checkOutput("rst_ready", 32'(busZ.ready), 32'd0);
    checkOutput("rst_a", busZ.a_readdataout, 32'd0);
    checkOutput("rst_b", busN.b_readdataout, 32'd0);
    waitReady("init_len_first");

    for (int i = 0; i < DEPTH; i++) applyStimulus(wrVec(2'(i / 32), 5'(i % 32), 32'hDEADBEEF));
    applyStimulus(rdVec(2'd1, 5'd3, 2'd2, 5'd0));
    checkOutput("fill_a", busZ.a_readdataout, 32'hDEADBEEF);
    checkOutput("fill_b_n", busN.b_readdataout, 32'hDEADBEEF);

    v = nopVec();
    v.rstn = 1'b0;
    applyStimulus(v);
    checkOutput("ready_drop", 32'(busZ.ready), 32'd0);
    checkOutput("ready_drop_a", busZ.a_readdataout, 32'd0);
    waitReady("init_len_pulse");
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < 32; r += 2) begin
        applyStimulus(rdVec(2'(t), 5'(r), 2'(t), 5'(r + 1)));
        checkOutput("clear_a", busN.a_readdataout, 32'd0);
        checkOutput("clear_b", busN.b_readdataout, 32'd0);
      end
    end

    applyStimulus(wrVec(2'd0, 5'd5, 32'h11111111));
    applyStimulus(wrVec(2'd3, 5'd5, 32'h33333333));
    applyStimulus(rdVec(2'd0, 5'd5, 2'd3, 5'd5));
    checkOutput("ctx_a", busZ.a_readdataout, 32'h11111111);
    checkOutput("ctx_b", busZ.b_readdataout, 32'h33333333);

    applyStimulus(wrVec(2'd2, 5'd0, 32'hFFFFFFFF));
    applyStimulus(rdVec(2'd2, 5'd0, 2'd2, 5'd0));
    checkOutput("zero_z", busZ.a_readdataout, 32'd0);
    checkOutput("zero_n", busN.a_readdataout, 32'hFFFFFFFF);

    applyStimulus(wrVec(2'd1, 5'd7, 32'h00000042));
    v = wrVec(2'd1, 5'd7, 32'hA5A5A5A5);
    v.aEn = 1'b1; v.aT = 2'd1; v.aR = 5'd7;
    applyStimulus(v);
`ifdef REG_FILE_MT_BYPASS_EN
    checkOutput("collide_a", busZ.a_readdataout, 32'hA5A5A5A5);
`else
    checkOutput("collide_a", busZ.a_readdataout, 32'h00000042);
`endif
    applyStimulus(rdVec(2'd1, 5'd7, 2'd1, 5'd7));
    checkOutput("collide_after", busZ.b_readdataout, 32'hA5A5A5A5);

    v = wrVec(2'd1, 5'd0, 32'h0BADF00D);
    v.aEn = 1'b1; v.aT = 2'd1; v.aR = 5'd0;
    applyStimulus(v);
    checkOutput("collide_zero", busZ.a_readdataout, 32'd0);

    applyStimulus(wrVec(2'd0, 5'd9, 32'h12345678));
    applyStimulus(rdVec(2'd0, 5'd9, 2'd0, 5'd9));
    for (int i = 0; i < 5; i++) begin
      v = nopVec();
      v.aT = 2'(i); v.aR = 5'(i + 3);
      applyStimulus(v);
      checkOutput("hold_a", busZ.a_readdataout, 32'h12345678);
    end

    applyStimulus(rdVec(2'd3, 5'd5, 2'd3, 5'd5));
    checkOutput("same_a", busZ.a_readdataout, 32'h33333333);
    checkOutput("same_b", busZ.b_readdataout, 32'h33333333);

    v = nopVec();
    v.rstn = 1'b0;
    applyStimulus(v);
    for (int i = 1; i <= 60; i++) begin
      if (i == 30) applyStimulus(wrVec(2'd0, 5'd5, 32'h00000BAD));
      else if (i == 40) applyStimulus(rdVec(2'd3, 5'd5, 2'd0, 5'd9));
      else applyStimulus(nopVec());
    end
    checkOutput("midinit_ready", 32'(busZ.ready), 32'd0);
    v = nopVec();
    v.rstn = 1'b0;
    applyStimulus(v);
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) applyStimulus(wrVec(2'd2, 5'd9, 32'h0000CAFE));
      else applyStimulus(nopVec());
    end
    v = nopVec();
    for (int i = 0; i < 20; i++) applyStimulus(v);
    begin
      int n;
      n = 30;
      while (!busZ.ready && n < 400) begin
        applyStimulus(nopVec());
        n++;
      end
      checkOutput("init_len_restart", 32'(n), 32'd128);
    end
    applyStimulus(rdVec(2'd0, 5'd5, 2'd2, 5'd9));
    checkOutput("midinit_wr_a", busN.a_readdataout, 32'd0);
    checkOutput("midinit_wr_b", busN.b_readdataout, 32'd0);
    applyStimulus(nopVec());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
